// File: rtl/posit_decode.sv
// posit<32,2> field decoder.
// Splits a 32-bit posit into sign, combined scale (4k+e) and a 1.27
// significand over three pipeline stages, and flags zero and NaR.
//
// Flow control: valid_in qualifies unum_in for the cycle in which en=1.
// There is no backpressure. en=0 freezes every stage, including the
// valid/finish tags. valid_out qualifies the result fields, and
// finish_out travels with the operand it was presented with.
module posit_decode #(
  parameter int unsigned N_PIPE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        valid_in,
  input  logic        finish_in,
  input  logic [31:0] unum_in,
  output logic        valid_out,
  output logic        finish_out,
  output logic        sign_out,
  output logic [7:0]  scale_out,
  output logic [27:0] sig_out,
  output logic        zero_out,
  output logic        isInf_out
);

  // Tags shift alongside the data stages, one bit per stage
  logic [N_PIPE-1:0] vld_sr;
  logic [N_PIPE-1:0] fin_sr;

  // Stage 1 registers
  logic        s1_sign;
  logic        s1_zero;
  logic        s1_nar;
  logic [30:0] s1_mag;

  // Stage 2 registers
  logic        s2_sign;
  logic        s2_zero;
  logic        s2_nar;
  logic [5:0]  s2_k;     // signed regime value, -31..30
  logic [28:0] s2_rem;   // bits after regime+terminator, left-aligned

  // Stage 2 combinational helpers
  logic [5:0]  run_c;
  logic        stop_c;
  logic [5:0]  k_c;
  logic [28:0] rem_c;

  // Count the regime run: leading magnitude bits equal to bit 30
  always_comb begin
    run_c  = 6'd0;
    stop_c = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (!stop_c) begin
        if (s1_mag[i] == s1_mag[30]) run_c = run_c + 6'd1;
        else                         stop_c = 1'b1;
      end
    end
  end

  // Regime value and the bits left after removing the m+1 regime bits.
  // Shifting by m-1 and keeping the low 29 bits drops the top m+1 bits
  // of the 31-bit field; past the end the result saturates to zero.
  always_comb begin
    k_c   = s1_mag[30] ? (run_c - 6'd1) : (6'd0 - run_c);
    rem_c = 29'(s1_mag << (run_c - 6'd1));
  end

  // Valid/finish tag delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      fin_sr <= '0;
    end else if (en) begin
      vld_sr <= {vld_sr[N_PIPE-2:0], valid_in};
      fin_sr <= {fin_sr[N_PIPE-2:0], finish_in};
    end
  end

  // Stage 1: sign, special-value flags, absolute value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_nar  <= 1'b0;
      s1_mag  <= '0;
    end else if (en) begin
      s1_sign <= unum_in[31];
      s1_zero <= (unum_in == 32'h0000_0000);
      s1_nar  <= (unum_in == 32'h8000_0000);
      s1_mag  <= unum_in[31] ? (~unum_in[30:0] + 31'd1) : unum_in[30:0];
    end
  end

  // Stage 2: regime decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_nar  <= 1'b0;
      s2_k    <= '0;
      s2_rem  <= '0;
    end else if (en) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_nar  <= s1_nar;
      s2_k    <= k_c;
      s2_rem  <= rem_c;
    end
  end

  // Stage 3: scale = 4k+e is just {k, e}; specials force fields to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_out   <= 1'b0;
      scale_out  <= '0;
      sig_out    <= '0;
      zero_out   <= 1'b0;
      isInf_out  <= 1'b0;
    end else if (en) begin
      zero_out  <= s2_zero;
      isInf_out <= s2_nar;
      if (s2_zero || s2_nar) begin
        sign_out  <= 1'b0;
        scale_out <= '0;
        sig_out   <= '0;
      end else begin
        sign_out  <= s2_sign;
        scale_out <= {s2_k, s2_rem[28:27]};
        sig_out   <= {1'b1, s2_rem[26:0]};
      end
    end
  end

  assign valid_out  = vld_sr[N_PIPE-1];
  assign finish_out = fin_sr[N_PIPE-1];

endmodule

// File: tb/tb_posit_decode.sv
// Bench for posit_decode: directed corner operands, a randomized stream
// with stalls, a finish-tagged stream and a mid-flight reset, all checked
// against a bit-walking posit reference decoder.
module tb_posit_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic        finish_in;
  logic [31:0] unum_in;
  logic        valid_out;
  logic        finish_out;
  logic        sign_out;
  logic [7:0]  scale_out;
  logic [27:0] sig_out;
  logic        zero_out;
  logic        isInf_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  scale;
    logic [27:0] sig;
    logic        zero;
    logic        inf;
  } res_t;

  // Operands in flight, oldest at index 2: {valid, finish, operand}
  logic [33:0] pipe [3];

  // Clock and DUT
  always #5 clk = ~clk;

  posit_decode #(.N_PIPE(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .valid_in   (valid_in),
    .finish_in  (finish_in),
    .unum_in    (unum_in),
    .valid_out  (valid_out),
    .finish_out (finish_out),
    .sign_out   (sign_out),
    .scale_out  (scale_out),
    .sig_out    (sig_out),
    .zero_out   (zero_out),
    .isInf_out  (isInf_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bit_at(input logic [31:0] v, input int idx);
    if (idx < 0) return 0;
    return int'(v[idx]);
  endfunction

  // Reference: walk the posit bit by bit from bit 30 downward
  function automatic res_t ref_decode(input logic [31:0] x);
    res_t r;
    logic [31:0] mag;
    int pos, m, k, e, frac;
    int rb;
    r = '0;
    if (x == 32'h0000_0000) begin
      r.zero = 1'b1;
    end else if (x == 32'h8000_0000) begin
      r.inf = 1'b1;
    end else begin
      r.sign = x[31];
      mag = x[31] ? (32'd0 - x) : x;
      rb  = bit_at(mag, 30);
      m   = 0;
      pos = 30;
      while (pos >= 0) begin
        if (bit_at(mag, pos) != rb) break;
        m++;
        pos--;
      end
      k = (rb == 1) ? (m - 1) : -m;
      pos--;                         // skip terminator bit
      e = 0;
      repeat (2) begin
        e = e * 2 + bit_at(mag, pos);
        pos--;
      end
      frac = 0;
      repeat (27) begin
        frac = frac * 2 + bit_at(mag, pos);
        pos--;
      end
      r.scale = 8'(4 * k + e);
      r.sig   = 28'((1 << 27) | frac);
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(valid_out),  32'd0);
    check({tag, "_finish"}, 32'(finish_out), 32'd0);
    check({tag, "_sign"},   32'(sign_out),   32'd0);
    check({tag, "_scale"},  32'(scale_out),  32'd0);
    check({tag, "_sig"},    32'(sig_out),    32'd0);
    check({tag, "_zero"},   32'(zero_out),   32'd0);
    check({tag, "_inf"},    32'(isInf_out),  32'd0);
  endtask

  // Driver: apply one cycle of inputs, advance the model, check outputs
  task automatic step(input logic e, input logic v, input logic f, input logic [31:0] d);
    res_t exp;
    en        = e;
    valid_in  = v;
    finish_in = f;
    unum_in   = d;
    @(posedge clk);
    #1;
    if (e) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = {v, f, d};
    end
    check("valid_out",  32'(valid_out),  32'(pipe[2][33]));
    check("finish_out", 32'(finish_out), 32'(pipe[2][32]));
    if (pipe[2][33]) begin
      exp = ref_decode(pipe[2][31:0]);
      check("sign_out",  32'(sign_out),  32'(exp.sign));
      check("scale_out", 32'(scale_out), 32'(exp.scale));
      check("sig_out",   32'(sig_out),   32'(exp.sig));
      check("zero_out",  32'(zero_out),  32'(exp.zero));
      check("isInf_out", 32'(isInf_out), 32'(exp.inf));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [6];
    logic [31:0] v;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h0000_0001;
    specials[4] = 32'h8000_0001;
    specials[5] = 32'hFFFF_FFFF;
    case ($urandom_range(0, 3))
      0:       v = specials[$urandom_range(0, 5)];
      1:       v = $urandom >> $urandom_range(0, 31);   // long zero regimes
      2:       v = ~($urandom >> $urandom_range(0, 31)); // long one regimes
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [31:0] dir_vec [8];

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    valid_in  = 1'b0;
    finish_in = 1'b0;
    unum_in   = '0;
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Directed corner operands, back to back, then drain
    dir_vec[0] = 32'h4000_0000;
    dir_vec[1] = 32'h4800_0000;
    dir_vec[2] = 32'hC000_0000;
    dir_vec[3] = 32'h5000_0001;
    dir_vec[4] = 32'h7FFF_FFFF;
    dir_vec[5] = 32'h0000_0001;
    dir_vec[6] = 32'h0000_0000;
    dir_vec[7] = 32'h8000_0000;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, dir_vec[i]);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Absolute expectations for the documented examples
    step(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("max_scale", 32'(scale_out), 32'h78);
    check("max_sig",   32'(sig_out),   32'h800_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0000_0001);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("min_scale", 32'(scale_out), 32'h88);
    step(1'b1, 1'b1, 1'b0, 32'h5000_0001);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("ex_scale", 32'(scale_out), 32'd2);
    check("ex_sig",   32'(sig_out),   32'h800_0001);

    // Randomized stream with random stalls, bubbles and finish tags
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), rand_operand());
    end
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Eight-operand stream, two stall cycles mid-stream, finish on last
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, (i == 7), rand_operand());
      if (i == 3) begin
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b1, 32'h1234_5678);
      end
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset with three operands in flight
    step(1'b1, 1'b1, 1'b0, 32'h4000_0000);
    step(1'b1, 1'b1, 1'b0, 32'h4800_0000);
    step(1'b1, 1'b1, 1'b1, 32'hC000_0000);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    rst = 1'b1;
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);

    // First operand after reset release
    step(1'b1, 1'b1, 1'b1, 32'h4800_0000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/posit_decode.md
POSIT_DECODE -- requirements
Module: posit_decode

Interface
REQ-001 The block SHALL have parameter N_PIPE, default 3, meaning pipeline latency in cycles; only the value 3 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port en, input, 1, pipeline advance enable; 0 = every stage holds.
REQ-005 The block SHALL have port valid_in, input, 1, unum_in carries an operand this cycle.
REQ-006 The block SHALL have port finish_in, input, 1, end-of-stream marker travelling with the operand.
REQ-007 The block SHALL have port unum_in, input, 32, posit<32,2> operand.
REQ-008 The block SHALL have port valid_out, output, 1, result fields valid.
REQ-009 The block SHALL have port finish_out, output, 1, finish_in delayed with its operand.
REQ-010 The block SHALL have port sign_out, output, 1, operand sign.
REQ-011 The block SHALL have port scale_out, output, 8, signed two's-complement scale 4k+e, range -120..+120.
REQ-012 The block SHALL have port sig_out, output, 28, significand 1.27 fixed point; hidden bit at bit 27.
REQ-013 The block SHALL have port zero_out, output, 1, operand is 0x0000_0000.
REQ-014 The block SHALL have port isInf_out, output, 1, operand is NaR 0x8000_0000.

Function
REQ-015 The block SHALL be a 3-stage pipeline with throughput one operand per cycle when en=1.
REQ-016 Stage 1 SHALL register: operand; sign = bit 31; zero/NaR flags; magnitude = two's complement of operand if sign=1, else operand.
REQ-017 Stage 2 SHALL count the regime run m, the number of leading magnitude bits [30:0] equal to bit 30, range 1..31.
REQ-018 Stage 2 SHALL compute k = m-1 when bit 30 = 1, and k = -m when bit 30 = 0.
REQ-019 Stage 2 SHALL shift out the regime and terminator bits (m+1 bits, saturating at 31) and register the remaining bits left-aligned.
REQ-020 Stage 3 SHALL take e = top 2 remaining bits, zero-padded when truncated.
REQ-021 Stage 3 SHALL take the fraction as the next 27 bits, zero-padded on the right.
REQ-022 Stage 3 SHALL register scale_out = 4k+e and sig_out = {1'b1, fraction}.
REQ-023 For zero or NaR operands, sign_out, scale_out and sig_out SHALL be 0 and only the matching flag SHALL be set.
REQ-024 valid_out and finish_out SHALL equal valid_in and finish_in exactly 3 enabled cycles earlier.
REQ-025 When en=0, all stage registers, including valid and finish, SHALL hold; no operand is lost or duplicated.
REQ-026 Stage registers with valid=0 SHALL still advance; their data is don't-care, but valid_out SHALL be 0.
REQ-027 All outputs SHALL be driven directly from stage-3 registers, with no combinational path from any input.

Reset
REQ-028 While rst=0, every pipeline register and every output SHALL be 0, asynchronously.
REQ-029 Operands in flight when rst asserts SHALL be discarded; no valid_out SHALL appear for them after release.
REQ-030 The first operand accepted after rst deasserts SHALL appear 3 enabled cycles later.

Verification
REQ-031 unum_in 0x4000_0000 -> sign 0, scale 0, sig 0x800_0000 after 3 cycles; unum_in 0x4800_0000 -> scale 1, sig 0x800_0000.
REQ-032 unum_in 0xC000_0000 -> sign 1, scale 0, sig 0x800_0000; unum_in 0x5000_0001 -> scale 2, sig 0x800_0001.
REQ-033 unum_in 0x7FFF_FFFF -> scale +120 (0x78); unum_in 0x0000_0001 -> scale -120 (0x88); both sig 0x800_0000.
REQ-034 unum_in 0x0000_0000 -> zero_out 1; unum_in 0x8000_0000 -> isInf_out 1; all other fields 0.
REQ-035 Back-to-back stream of 8 operands, en=0 for 2 cycles mid-stream, finish_in on the last operand -> 8 in-order results; finish_out only on the 8th; no gaps other than the stall.
REQ-036 rst pulsed low with 3 operands in flight -> outputs 0 immediately; no valid_out for those operands after release.
